// File: rtl/frame_packetizer.sv
// frame_packetizer: buffers a captured raster frame in a small FIFO and emits it as one
// Avalon-ST video packet (type-0 header + WIDTH*HEIGHT pixels). Define FRAME_PACKETIZER_STATS_EN for frame/trunc counters.
//   state   | meaning
//   IDLE    | waiting for pix_vsync
//   HEADER  | presenting the header beat
//   PIXELS  | streaming FIFO pixels, or zero pads once the frame is truncated
module frame_packetizer #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_vsync,
    output logic [23:0] src_data,
    output logic        src_startofpacket,
    output logic        src_endofpacket,
    output logic        src_valid,
    input  logic        src_ready,
    output logic        busy,
    output logic        overflow
`ifdef FRAME_PACKETIZER_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] trunc_count
`endif
);

    localparam int          DEPTH = 1 << FIFO_AW;
    localparam logic [23:0] TOTAL = 24'(WIDTH * HEIGHT);
    localparam logic [23:0] LAST  = TOTAL - 24'd1;

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PIXELS} state_t;

    state_t           state_q, state_d;
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [23:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic             cap_en_q, cap_en_d;
    logic             trunc_q, trunc_d;
    logic             overflow_q, overflow_d;
    logic [23:0]      mem_q [DEPTH];

    logic fifo_empty, fifo_full, vsync_busy, cap_active;
    logic pop, wr_en, ovf_hit, pix_hs, frame_done;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    // A vsync outside IDLE belongs to a frame we will not start, so its pixel is not captured.
    assign vsync_busy = pix_vsync && (state_q != ST_IDLE);
    assign cap_active = (cap_en_q || (state_q == ST_IDLE && pix_vsync)) && !vsync_busy;
    assign pop        = (state_q == ST_PIXELS) && !fifo_empty && src_ready;
    assign wr_en      = pix_valid && cap_active && (!fifo_full || pop);
    assign ovf_hit    = pix_valid && cap_active && fifo_full && !pop;
    assign pix_hs     = (state_q == ST_PIXELS) && src_valid && src_ready;
    assign frame_done = pix_hs && (rd_cnt_q == LAST);

    always_comb begin
        src_valid         = 1'b0;
        src_startofpacket = 1'b0;
        src_endofpacket   = 1'b0;
        src_data          = 24'h000000;
        case (state_q)
            ST_HEADER: begin
                src_valid         = 1'b1;
                src_startofpacket = 1'b1;
            end
            ST_PIXELS: begin
                src_valid       = !fifo_empty || trunc_q;
                src_data        = fifo_empty ? 24'h000000 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
                src_endofpacket = src_valid && (rd_cnt_q == LAST);
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q + {{FIFO_AW{1'b0}}, wr_en};
        rd_ptr_d   = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
        wr_cnt_d   = wr_cnt_q + {23'd0, wr_en};
        rd_cnt_d   = rd_cnt_q + {23'd0, pix_hs};
        cap_en_d   = cap_en_q;
        trunc_d    = trunc_q;
        overflow_d = overflow_q | ovf_hit;
        if (state_q == ST_IDLE && pix_vsync) begin
            state_d  = ST_HEADER;
            cap_en_d = 1'b1;
        end
        if (state_q == ST_HEADER && src_ready) state_d = ST_PIXELS;
        if (wr_en && wr_cnt_q == LAST) cap_en_d = 1'b0;
        if (ovf_hit || vsync_busy) begin
            cap_en_d = 1'b0;
            trunc_d  = 1'b1;
        end
        if (frame_done) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            cap_en_d = 1'b0;
            trunc_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            cap_en_q   <= 1'b0;
            trunc_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            cap_en_q   <= cap_en_d;
            trunc_q    <= trunc_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= pix_data;
    end

`ifdef FRAME_PACKETIZER_STATS_EN
    logic [15:0] frame_count_q, frame_count_d, trunc_count_q, trunc_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        trunc_count_d = trunc_count_q;
        if (frame_done) begin
            frame_count_d = frame_count_q + 16'd1;
            if (trunc_q) trunc_count_d = trunc_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= '0;
            trunc_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            trunc_count_q <= trunc_count_d;
        end
    end

    assign frame_count = frame_count_q;
    assign trunc_count = trunc_count_q;
`endif

endmodule

// File: tb/tb_frame_packetizer.sv
// Directed bench for frame_packetizer at WIDTH=4, HEIGHT=2, FIFO_AW=2; beats are
// collected on the falling edge and compared against hand-written packets.
module tb_frame_packetizer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_vsync;
    logic [23:0] src_data;
    logic        src_startofpacket;
    logic        src_endofpacket;
    logic        src_valid;
    logic        src_ready;
    logic        busy;
    logic        overflow;
`ifdef FRAME_PACKETIZER_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] trunc_count;
`endif

    frame_packetizer #(.WIDTH(4), .HEIGHT(2), .FIFO_AW(2)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pix_data          (pix_data),
        .pix_valid         (pix_valid),
        .pix_vsync         (pix_vsync),
        .src_data          (src_data),
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .busy              (busy),
        .overflow          (overflow)
`ifdef FRAME_PACKETIZER_STATS_EN
        ,
        .frame_count       (frame_count),
        .trunc_count       (trunc_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          rmode = 0;
    logic        tog   = 1'b0;
    logic [25:0] beats [$];
    logic [25:0] exp_q [9];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ready mode: 0 always high, 1 toggling, 2 held low
    task automatic cyc(input logic v, input logic vs, input logic [23:0] d);
        pix_valid = v;
        pix_vsync = vs;
        pix_data  = d;
        case (rmode)
            0: src_ready = 1'b1;
            1: begin src_ready = tog; tog = ~tog; end
            default: src_ready = 1'b0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic lead_vsync);
        if (lead_vsync) begin
            cyc(1'b0, 1'b1, 24'd0);
            cyc(1'b0, 1'b0, 24'd0);
            for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 24'(i));
        end else begin
            cyc(1'b1, 1'b1, 24'd1);
            for (int i = 2; i <= 8; i++) cyc(1'b1, 1'b0, 24'(i));
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (beats.size() >= 9 && !busy) break;
            cyc(1'b0, 1'b0, 24'd0);
        end
    endtask

    task automatic set_exp(input logic [23:0] p0, p1, p2, p3, p4, p5, p6, p7);
        logic [23:0] p [8];
        p = '{p0, p1, p2, p3, p4, p5, p6, p7};
        exp_q[0] = {2'b10, 24'h000000};
        for (int i = 0; i < 8; i++) exp_q[i+1] = {1'b0, (i == 7), p[i]};
    endtask

    task automatic check_pkt(input string tag);
        chk($sformatf("%s_nbeats", tag), beats.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < beats.size()) chk($sformatf("%s_beat%0d", tag, i), {6'd0, beats[i]}, {6'd0, exp_q[i]});
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        pix_vsync = 1'b0;
        pix_data  = 24'd0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        beats.delete();
    endtask

    // Falling-edge monitor: records handshaked beats and checks stall stability.
    logic        stall_q = 1'b0;
    logic [26:0] prev_q  = '0;
    initial begin
        logic [26:0] cur;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_q = 1'b0;
            end else begin
                cur = {src_valid, src_startofpacket, src_endofpacket, src_data};
                if (stall_q) chk("stall_hold", {5'd0, cur}, {5'd0, prev_q});
                if (src_valid && src_ready) beats.push_back({src_startofpacket, src_endofpacket, src_data});
                stall_q = src_valid && !src_ready;
                prev_q  = cur;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pix_valid = 1'b0;
        pix_vsync = 1'b0;
        pix_data  = 24'd0;
        src_ready = 1'b0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", src_valid, 0);
        chk("rst_sop", src_startofpacket, 0);
        chk("rst_eop", src_endofpacket, 0);
        chk("rst_data", src_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame with ready held high.
        rmode = 0;
        beats.delete();
        set_exp(24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8);
        send8(1'b0);
        drain(40);
        check_pkt("full");
        chk("full_busy", busy, 0);
        chk("full_ovf", overflow, 0);
        // Pixels in IDLE without vsync must be ignored.
        beats.delete();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 24'h9);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 24'd0);
        chk("idle_ignore_beats", beats.size(), 0);
        chk("idle_ignore_busy", busy, 0);

        // Ready toggling every cycle; FIFO hits full with a simultaneous pop.
        do_reset();
        rmode = 1;
        tog   = 1'b0;
        set_exp(24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8);
        send8(1'b1);
        drain(60);
        check_pkt("toggle");
        chk("toggle_ovf", overflow, 0);
        chk("toggle_busy", busy, 0);

        // Sink stalled for the whole capture: 4 stored, rest dropped, pads fill in.
        do_reset();
        rmode = 2;
        set_exp(24'd1, 24'd2, 24'd3, 24'd4, 24'd0, 24'd0, 24'd0, 24'd0);
        send8(1'b0);
        chk("stall_ovf", overflow, 1);
        chk("stall_busy", busy, 1);
        rmode = 0;
        drain(40);
        check_pkt("stall");
        chk("stall_ovf_sticky", overflow, 1);

        // Second vsync after 3 pixels truncates; no new frame starts.
        do_reset();
        rmode = 0;
        set_exp(24'd1, 24'd2, 24'd3, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0);
        cyc(1'b1, 1'b1, 24'd1);
        cyc(1'b1, 1'b0, 24'd2);
        cyc(1'b1, 1'b0, 24'd3);
        cyc(1'b0, 1'b1, 24'd0);
        drain(40);
        check_pkt("trunc");
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 24'd0);
        chk("trunc_no_restart_beats", beats.size(), 9);
        chk("trunc_no_restart_busy", busy, 0);
        chk("trunc_ovf", overflow, 0);
`ifdef FRAME_PACKETIZER_STATS_EN
        chk("stats_frame_count", frame_count, 1);
        chk("stats_trunc_count", trunc_count, 1);
`endif

        // Asynchronous reset in the middle of PIXELS.
        do_reset();
        rmode = 0;
        cyc(1'b1, 1'b1, 24'd1);
        cyc(1'b1, 1'b0, 24'd2);
        cyc(1'b1, 1'b0, 24'd3);
        cyc(1'b1, 1'b0, 24'd4);
        pix_valid = 1'b0;
        chk("pre_rst_valid", src_valid, 1);
        chk("pre_rst_data", src_data, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", src_valid, 0);
        chk("mid_rst_sop", src_startofpacket, 0);
        chk("mid_rst_eop", src_endofpacket, 0);
        chk("mid_rst_data", src_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", overflow, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        beats.delete();
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 24'd0);
        chk("post_rst_quiet", beats.size(), 0);
        set_exp(24'd1, 24'd2, 24'd3, 24'd4, 24'd5, 24'd6, 24'd7, 24'd8);
        send8(1'b0);
        drain(40);
        check_pkt("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
